// File: rtl/pipe_pkg.sv
// Shared helpers for the elastic pipeline-register chain.
package pipe_pkg;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 32'sd0;
    v = n - 32'sd1;
    while (v > 32'sd0) begin
      r = r + 32'sd1;
      v = v >>> 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic stage: valid/data register with load, hold and in-place flush.
module pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_ready,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_flush,
  output logic             o_valid,
  output logic             o_eff_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Data only moves with a real item so a bubble never clobbers the last payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= {WIDTH{1'b0}};
    end else if (i_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end else begin
        r_data <= r_data;
      end
    end else begin
      r_valid <= r_valid & ~i_flush;
      r_data  <= r_data;
    end
  end

  assign o_valid     = r_valid;
  assign o_eff_valid = r_valid & ~i_flush;
  assign o_data      = r_data;

endmodule

// File: rtl/pipe_regs.sv
// Parametrised elastic pipeline-register chain with per-stage flush and
// optional bubble collapsing; stage 0 faces the input, stage DEPTH-1 the output.
module pipe_regs
  import pipe_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int COLLAPSE = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  input  logic [DEPTH-1:0]             flush,
  output logic [DEPTH-1:0]             stage_valid,
  output logic [clog2(DEPTH+1)-1:0]    occupancy
);

  localparam int OCC_W = clog2(DEPTH + 1);

  logic [DEPTH-1:0] w_v;
  logic [DEPTH-1:0] w_ev;
  logic [DEPTH-1:0] w_rdy;
  logic [DEPTH-1:0] w_in_v;
  logic [WIDTH-1:0] w_d    [DEPTH];
  logic [WIDTH-1:0] w_in_d [DEPTH];
  logic [OCC_W-1:0] w_occ;

  // Ready chain: with collapsing, a stage may advance whenever any stage at or
  // below it toward the output is empty; otherwise the whole chain stalls together.
  always_comb begin
    w_rdy = {DEPTH{1'b0}};
    if (COLLAPSE != 0) begin
      w_rdy[DEPTH-1] = out_ready | ~w_ev[DEPTH-1];
      for (int i = DEPTH - 2; i >= 0; i--) begin
        w_rdy[i] = w_rdy[i+1] | ~w_ev[i];
      end
    end else begin
      w_rdy = {DEPTH{out_ready}};
    end
  end

  // Each stage is fed by its upstream neighbour's effective valid, so flushes never travel.
  always_comb begin
    w_in_v    = {DEPTH{1'b0}};
    w_in_v[0] = in_valid;
    w_in_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      w_in_v[i] = w_ev[i-1];
      w_in_d[i] = w_d[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_ready     (w_rdy[g]),
      .i_valid     (w_in_v[g]),
      .i_data      (w_in_d[g]),
      .i_flush     (flush[g]),
      .o_valid     (w_v[g]),
      .o_eff_valid (w_ev[g]),
      .o_data      (w_d[g])
    );
  end

  // Occupancy counts raw valids so the hazard unit sees a flushed item until the edge.
  always_comb begin
    w_occ = {OCC_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      w_occ = w_occ + OCC_W'(w_v[i]);
    end
  end

  assign in_ready    = w_rdy[0];
  assign out_valid   = w_ev[DEPTH-1];
  assign out_data    = w_d[DEPTH-1];
  assign stage_valid = w_v;
  assign occupancy   = w_occ;

endmodule

// File: tb/tb_pipe_regs.sv
// Bench for pipe_regs: a collapsing and a lockstep instance share one stimulus stream.
module tb_pipe_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic [3:0]  flush;

  logic        c_in_ready, c_out_valid, l_in_ready, l_out_valid;
  logic [31:0] c_out_data, l_out_data;
  logic [3:0]  c_stage_valid, l_stage_valid;
  logic [2:0]  c_occ, l_occ;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference model state: valid vectors and payload arrays per instance.
  logic [3:0]  cv, lv;
  logic [31:0] cd [4];
  logic [31:0] ld [4];

  always #5 clk = ~clk;

  pipe_regs #(.WIDTH(32), .DEPTH(4), .COLLAPSE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data), .flush(flush),
    .stage_valid(c_stage_valid), .occupancy(c_occ)
  );

  pipe_regs #(.WIDTH(32), .DEPTH(4), .COLLAPSE(0)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l_in_ready), .in_data(in_data),
    .out_valid(l_out_valid), .out_ready(out_ready), .out_data(l_out_data), .flush(flush),
    .stage_valid(l_stage_valid), .occupancy(l_occ)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'd0; flush = 4'd0; out_ready = 1'b1;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'd0; flush = 4'd0; out_ready = 1'b0;
    #2;
    chk_cnt++;
    if ({c_out_valid, c_out_data, c_stage_valid, c_occ} !== 40'd0)
      $display("FAIL reset_c_state: got ov=%b od=%h sv=%b occ=%0d want all zero", c_out_valid, c_out_data, c_stage_valid, c_occ);
    else pass_cnt++;
    chk_cnt++;
    if ({l_out_valid, l_out_data, l_stage_valid, l_occ} !== 40'd0)
      $display("FAIL reset_l_state: got ov=%b od=%h sv=%b occ=%0d want all zero", l_out_valid, l_out_data, l_stage_valid, l_occ);
    else pass_cnt++;
    chk_cnt++;
    if ({c_in_ready, l_in_ready} !== 2'b10)
      $display("FAIL reset_in_ready_or0: got c=%b l=%b want c=1 l=0", c_in_ready, l_in_ready);
    else pass_cnt++;
    out_ready = 1'b1;
    #1;
    chk_cnt++;
    if ({c_in_ready, l_in_ready} !== 2'b11)
      $display("FAIL reset_in_ready_or1: got c=%b l=%b want c=1 l=1", c_in_ready, l_in_ready);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_streaming();
    logic ev;
    do_reset();
    for (int t = 0; t <= 12; t++) begin
      in_valid = (t < 8);
      in_data  = 32'(t + 1);
      #1;
      ev = (t >= 4) && (t < 12);
      chk_cnt++;
      if (c_out_valid !== ev || (ev && c_out_data !== 32'(t - 3)) || c_in_ready !== 1'b1)
        $display("FAIL stream_c t=%0d: got ov=%b od=%h ir=%b want ov=%b od=%h ir=1", t, c_out_valid, c_out_data, c_in_ready, ev, t - 3);
      else pass_cnt++;
      chk_cnt++;
      if (l_out_valid !== ev || (ev && l_out_data !== 32'(t - 3)))
        $display("FAIL stream_l t=%0d: got ov=%b od=%h want ov=%b od=%h", t, l_out_valid, l_out_data, ev, t - 3);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 1'b1; in_data = 32'hA;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 32'hB + 32'(k);
      #1;
      chk_cnt++;
      if ({c_in_ready, l_in_ready} !== 2'b10)
        $display("FAIL bp_accept k=%0d: got c_ir=%b l_ir=%b want 1 0", k, c_in_ready, l_in_ready);
      else pass_cnt++;
      tick();
    end
    in_data = 32'hE;
    #1;
    chk_cnt++;
    if ({c_in_ready, c_occ, c_stage_valid} !== {1'b0, 3'd4, 4'hF})
      $display("FAIL bp_full_c: got ir=%b occ=%0d sv=%b want 0 4 1111", c_in_ready, c_occ, c_stage_valid);
    else pass_cnt++;
    chk_cnt++;
    if ({l_in_ready, l_occ, l_stage_valid} !== {1'b0, 3'd1, 4'b1000})
      $display("FAIL bp_stall_l: got ir=%b occ=%0d sv=%b want 0 1 1000", l_in_ready, l_occ, l_stage_valid);
    else pass_cnt++;
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_cnt++;
      if (c_out_valid !== 1'b1 || c_out_data !== 32'hA + 32'(k))
        $display("FAIL bp_drain_c k=%0d: got ov=%b od=%h want 1 %h", k, c_out_valid, c_out_data, 32'hA + 32'(k));
      else pass_cnt++;
      chk_cnt++;
      if (l_out_valid !== (k == 0) || (k == 0 && l_out_data !== 32'hA))
        $display("FAIL bp_drain_l k=%0d: got ov=%b od=%h want ov=%b od=a", k, l_out_valid, l_out_data, k == 0);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_bubbles();
    logic [3:0] cexp, lexp;
    cexp = 4'b0011;
    lexp = 4'b1010;
    do_reset();
    in_valid = 1'b1; in_data = 32'h21; tick();
    in_valid = 1'b0;                    tick();
    in_valid = 1'b1; in_data = 32'h22; tick();
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) tick();
    chk_cnt++;
    if ({c_stage_valid, l_stage_valid} !== {4'b1100, 4'b0101})
      $display("FAIL bubble_stall: got c_sv=%b l_sv=%b want 1100 0101", c_stage_valid, l_stage_valid);
    else pass_cnt++;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_cnt++;
      if (c_out_valid !== cexp[k] || (cexp[k] && c_out_data !== ((k == 0) ? 32'h21 : 32'h22)))
        $display("FAIL bubble_out_c k=%0d: got ov=%b od=%h want ov=%b", k, c_out_valid, c_out_data, cexp[k]);
      else pass_cnt++;
      chk_cnt++;
      if (l_out_valid !== lexp[k] || (lexp[k] && l_out_data !== ((k == 1) ? 32'h21 : 32'h22)))
        $display("FAIL bubble_out_l k=%0d: got ov=%b od=%h want ov=%b", k, l_out_valid, l_out_data, lexp[k]);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_flush();
    logic [31:0] cq[$];
    logic [31:0] lq[$];
    do_reset();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 32'h11 + 32'(k);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0; flush = 4'b0110;
    #1;
    chk_cnt++;
    if ({c_occ, l_occ} !== {3'd4, 3'd4})
      $display("FAIL flush_occ_before: got c=%0d l=%0d want 4 4", c_occ, l_occ);
    else pass_cnt++;
    tick();
    flush = 4'b0000;
    #1;
    chk_cnt++;
    if ({c_occ, l_occ} !== {3'd2, 3'd2})
      $display("FAIL flush_occ_after: got c=%0d l=%0d want 2 2", c_occ, l_occ);
    else pass_cnt++;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (c_out_valid) cq.push_back(c_out_data);
      if (l_out_valid) lq.push_back(l_out_data);
      tick();
    end
    chk_cnt++;
    if (cq.size() != 2 || cq[0] !== 32'h11 || cq[1] !== 32'h14)
      $display("FAIL flush_seq_c: got %0d items %p want 11 14", cq.size(), cq);
    else pass_cnt++;
    chk_cnt++;
    if (lq.size() != 2 || lq[0] !== 32'h11 || lq[1] !== 32'h14)
      $display("FAIL flush_seq_l: got %0d items %p want 11 14", lq.size(), lq);
    else pass_cnt++;
  endtask

  task automatic test_flush_out();
    do_reset();
    in_valid = 1'b1; in_data = 32'h55; tick();
    in_valid = 1'b0;
    repeat (3) tick();
    flush = 4'b1000;
    #1;
    chk_cnt++;
    if ({c_out_valid, l_out_valid, c_in_ready} !== 3'b001)
      $display("FAIL flush_out_valid: got c_ov=%b l_ov=%b c_ir=%b want 0 0 1", c_out_valid, l_out_valid, c_in_ready);
    else pass_cnt++;
    tick();
    flush = 4'b0000;
    #1;
    chk_cnt++;
    if ({c_out_valid, l_out_valid, c_occ, l_occ} !== 8'd0)
      $display("FAIL flush_out_gone: got c_ov=%b l_ov=%b c_occ=%0d l_occ=%0d want all 0", c_out_valid, l_out_valid, c_occ, l_occ);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 32'h31 + 32'(k);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk_cnt++;
    if ({c_occ, c_out_valid, l_occ, l_out_valid} !== {3'd3, 1'b1, 3'd3, 1'b1})
      $display("FAIL rstmid_before: got c_occ=%0d c_ov=%b l_occ=%0d l_ov=%b want 3 1 3 1", c_occ, c_out_valid, l_occ, l_out_valid);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({c_occ, c_out_valid, c_stage_valid, l_occ, l_out_valid, l_stage_valid} !== 16'd0)
      $display("FAIL rstmid_async: got c_occ=%0d c_ov=%b l_occ=%0d l_ov=%b want all 0", c_occ, c_out_valid, l_occ, l_out_valid);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1; in_data = 32'h77;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    chk_cnt++;
    if ({c_out_valid, l_out_valid} !== 2'b00)
      $display("FAIL rstmid_early: got c_ov=%b l_ov=%b want 0 0", c_out_valid, l_out_valid);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({c_out_valid, c_out_data, l_out_valid, l_out_data} !== {1'b1, 32'h77, 1'b1, 32'h77})
      $display("FAIL rstmid_latency: got c=%b/%h l=%b/%h want 1/77 1/77", c_out_valid, c_out_data, l_out_valid, l_out_data);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [3:0]  cev, lev, crdy, ncv, nlv;
    logic [31:0] ncd [4];
    logic [31:0] nld [4];
    logic        inv;
    logic [31:0] ind;
    do_reset();
    cv = 4'd0; lv = 4'd0;
    for (int i = 0; i < 4; i++) begin cd[i] = 32'd0; ld[i] = 32'd0; end
    for (int n = 0; n < 400; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom();
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      #1;
      cev = cv & ~flush;
      lev = lv & ~flush;
      // A collapsing stage may move if the output drains or any stage from it onward is empty.
      for (int i = 0; i < 4; i++) begin
        crdy[i] = out_ready;
        for (int j = i; j < 4; j++) if (!cev[j]) crdy[i] = 1'b1;
      end
      chk_cnt++;
      if ({c_in_ready, c_out_valid, c_out_data, c_stage_valid, c_occ} !== {crdy[0], cev[3], cd[3], cv, 3'($countones(cv))})
        $display("FAIL rand_c n=%0d: got ir=%b ov=%b od=%h sv=%b occ=%0d want ir=%b ov=%b od=%h sv=%b",
                 n, c_in_ready, c_out_valid, c_out_data, c_stage_valid, c_occ, crdy[0], cev[3], cd[3], cv);
      else pass_cnt++;
      chk_cnt++;
      if ({l_in_ready, l_out_valid, l_out_data, l_stage_valid, l_occ} !== {out_ready, lev[3], ld[3], lv, 3'($countones(lv))})
        $display("FAIL rand_l n=%0d: got ir=%b ov=%b od=%h sv=%b occ=%0d want ir=%b ov=%b od=%h sv=%b",
                 n, l_in_ready, l_out_valid, l_out_data, l_stage_valid, l_occ, out_ready, lev[3], ld[3], lv);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
        if (i == 0) begin inv = in_valid; ind = in_data; end
        else begin inv = cev[i-1]; ind = cd[i-1]; end
        ncv[i] = crdy[i] ? inv : cev[i];
        ncd[i] = (crdy[i] && inv) ? ind : cd[i];
      end
      // Lockstep: whole chain shifts on out_ready, otherwise everything holds minus flushed items.
      nlv = lev;
      for (int i = 0; i < 4; i++) nld[i] = ld[i];
      if (out_ready) begin
        nlv = {lev[2:0], in_valid};
        if (in_valid) nld[0] = in_data;
        for (int i = 1; i < 4; i++) if (lev[i-1]) nld[i] = ld[i-1];
      end
      @(posedge clk);
      cv = ncv; lv = nlv;
      for (int i = 0; i < 4; i++) begin cd[i] = ncd[i]; ld[i] = nld[i]; end
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0; flush = 4'd0;
    #1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubbles();
    test_flush();
    test_flush_out();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
